// File: rtl/custom_read.sv
// Block reader: streams rd_len consecutive RAM words from rd_base_addr to a valid/ready consumer.
// Optional delivered-word check at CHECK_ADDR is built only when CUSTOM_READ_CHECK_EN is defined.
module custom_read #(
    parameter int                W_ADDR     = 12,
    parameter int                W_DATA     = 128,
    parameter int                RD_LAT     = 2,
    parameter int                FIFO_DEPTH = 4,
    parameter int                CHECK_ADDR = 5,
    parameter logic [W_DATA-1:0] CHECK_DATA = 128'hffffffff50
) (
    input  logic              clk,
    input  logic              custom_rst,
    input  logic              rd_start,
    input  logic [W_ADDR-1:0] rd_base_addr,
    input  logic [W_ADDR:0]   rd_len,
    output logic [W_ADDR-1:0] custom_rd_addr,
    output logic              custom_rden_b,
    input  logic [W_DATA-1:0] custom_rd_q,
    output logic [W_DATA-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_busy,
    output logic              rd_done,
    output logic              check_fail,
    output logic              check_seen
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [W_ADDR-1:0] addr;
    logic [W_ADDR:0]   remaining;
    logic              zero_done;
    logic [RD_LAT-1:0] vld_sr;
    logic [IW-1:0]     inflight_cnt;
    logic [W_DATA-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     fifo_cnt;
    logic              start_ok;
    logic              issue;
    logic              push;
    logic              pop;
    logic              drain_done;

    assign rd_busy        = (state != IDLE) || zero_done;
    assign start_ok       = rd_start && !rd_busy;
    assign push           = vld_sr[RD_LAT-1];
    assign rd_valid       = (fifo_cnt != '0);
    assign pop            = rd_valid && rd_ready;
    assign rd_data        = rd_valid ? fifo_mem[rd_ptr] : '0;
    assign custom_rd_addr = addr;
    assign custom_rden_b  = issue;
    assign rd_done        = zero_done || drain_done;

    always_ff @(posedge clk) begin
        if (custom_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Credits are the registered in-flight and FIFO counts, so a same-cycle pop never over-issues.
    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        drain_done = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok && rd_len != '0) state_nxt = ISSUE;
            end
            ISSUE: begin
                issue = (int'(inflight_cnt) + int'(fifo_cnt)) < FIFO_DEPTH;
                if (issue && remaining == (W_ADDR+1)'(1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                drain_done = (inflight_cnt == '0) && (fifo_cnt == '0);
                if (drain_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (custom_rst) begin
            addr      <= '0;
            remaining <= '0;
            zero_done <= 1'b0;
        end else begin
            zero_done <= start_ok && (rd_len == '0);
            if (start_ok && rd_len != '0) begin
                addr      <= rd_base_addr;
                remaining <= rd_len;
            end else if (issue) begin
                addr      <= addr + W_ADDR'(1);
                remaining <= remaining - (W_ADDR+1)'(1);
            end
        end
    end

    // One bit per issued read, arriving at the tail exactly when custom_rd_q holds that word.
    always_ff @(posedge clk) begin
        if (custom_rst) begin
            vld_sr       <= '0;
            inflight_cnt <= '0;
        end else begin
            vld_sr <= (vld_sr << 1) | RD_LAT'(issue);
            case ({issue, push})
                2'b10:   inflight_cnt <= inflight_cnt + IW'(1);
                2'b01:   inflight_cnt <= inflight_cnt - IW'(1);
                default: inflight_cnt <= inflight_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= custom_rd_q;
    end

    always_ff @(posedge clk) begin
        if (custom_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    logic unused_check_params;
    assign unused_check_params = ^{CHECK_DATA, W_ADDR'(CHECK_ADDR)};

`ifdef CUSTOM_READ_CHECK_EN
    logic [W_ADDR-1:0] chk_base;
    logic [W_ADDR-1:0] accepted_cnt;
    logic              seen_q;
    logic              fail_q;

    // Delivered-word address is reconstructed from the block base and the accept count.
    always_ff @(posedge clk) begin
        if (custom_rst) begin
            chk_base     <= '0;
            accepted_cnt <= '0;
            seen_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            if (start_ok) begin
                chk_base     <= rd_base_addr;
                accepted_cnt <= '0;
            end else if (pop) begin
                accepted_cnt <= accepted_cnt + W_ADDR'(1);
            end
            if (pop && (chk_base + accepted_cnt) == W_ADDR'(CHECK_ADDR)) begin
                seen_q <= 1'b1;
                if (rd_data != CHECK_DATA) fail_q <= 1'b1;
            end
        end
    end

    assign check_seen = seen_q;
    assign check_fail = fail_q;
`else
    assign check_seen = 1'b0;
    assign check_fail = 1'b0;
`endif

endmodule

// File: tb/tb_custom_read.sv
// Self-checking bench for custom_read: RAM model with fixed read latency and a data/address scoreboard.
// Flag expectations follow CUSTOM_READ_CHECK_EN as seen by this bench.
module tb_custom_read;

    localparam int W_ADDR     = 12;
    localparam int W_DATA     = 128;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              custom_rst = 1'b1;
    logic              rd_start = 1'b0;
    logic [W_ADDR-1:0] rd_base_addr = '0;
    logic [W_ADDR:0]   rd_len = '0;
    logic [W_ADDR-1:0] custom_rd_addr;
    logic              custom_rden_b;
    logic [W_DATA-1:0] custom_rd_q;
    logic [W_DATA-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready = 1'b1;
    logic              rd_busy;
    logic              rd_done;
    logic              check_fail;
    logic              check_seen;

    logic [W_DATA-1:0] ram  [4096];
    logic [W_DATA-1:0] pipe [RD_LAT];
    logic [W_DATA-1:0] exp_data [$];
    logic [W_ADDR-1:0] exp_addr [$];
    int errors = 0;
    int checks = 0;
    int overflow_cnt = 0;

    custom_read #(
        .W_ADDR(W_ADDR), .W_DATA(W_DATA), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .custom_rst(custom_rst), .rd_start(rd_start),
        .rd_base_addr(rd_base_addr), .rd_len(rd_len),
        .custom_rd_addr(custom_rd_addr), .custom_rden_b(custom_rden_b),
        .custom_rd_q(custom_rd_q), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_busy(rd_busy), .rd_done(rd_done),
        .check_fail(check_fail), .check_seen(check_seen)
    );

    always #5 clk = ~clk;

    // RAM read port: word appears on custom_rd_q RD_LAT cycles after the enable cycle.
    always @(posedge clk) begin
        pipe[0] <= custom_rden_b ? ram[custom_rd_addr] : '0;
        for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign custom_rd_q = pipe[RD_LAT-1];

    always @(posedge clk) begin
        if (!custom_rst) begin
            assert (!(dut.push && dut.fifo_cnt == FIFO_DEPTH)) else begin
                overflow_cnt++;
                $display("[TB] FAIL fifo_overflow: push with fifo_cnt=%0d, required < %0d", dut.fifo_cnt, FIFO_DEPTH);
            end
        end
    end

    task automatic start_block(input logic [W_ADDR-1:0] base, input logic [W_ADDR:0] len);
        rd_base_addr = base;
        rd_len       = len;
        rd_start     = 1'b1;
        @(negedge clk);
        rd_start     = 1'b0;
    endtask

    task automatic test_reset();
        custom_rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({custom_rden_b, rd_valid, rd_busy, rd_done} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got rden/valid/busy/done=%b, expected 0000",
                     {custom_rden_b, rd_valid, rd_busy, rd_done});
        end
        checks++;
        if (rd_data !== '0 || custom_rd_addr !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: got data=%h addr=%h, expected 0/0", rd_data, custom_rd_addr);
        end
        checks++;
        if ({check_seen, check_fail} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_flags: got seen/fail=%b, expected 00", {check_seen, check_fail});
        end
        custom_rst = 1'b0;
        @(negedge clk);
    endtask

    // Runs one block, scoreboarding addresses and data, credit limit and stall stability.
    task automatic test_stream(input string name, input logic [W_ADDR-1:0] base, input int len,
                               input bit toggle, input bit exact);
        logic [W_DATA-1:0] d;
        logic [W_DATA-1:0] prev_data = '0;
        logic [W_ADDR-1:0] a;
        int issued = 0;
        int accepted = 0;
        bit done = 0;
        bit prev_stall = 0;
        exp_data.delete();
        exp_addr.delete();
        for (int i = 0; i < len; i++) begin
            a = base + W_ADDR'(i);
            exp_addr.push_back(a);
            exp_data.push_back(ram[a]);
        end
        rd_ready = 1'b1;
        start_block(base, (W_ADDR+1)'(len));
        for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
            if (exact) begin
                checks++;
                if ({custom_rden_b, rd_valid, rd_done, rd_busy} !==
                    {cyc <= len, cyc >= 4 && cyc <= len + 3, cyc == len + 4, cyc <= len + 4}) begin
                    errors++;
                    $display("[TB] FAIL %s_timing cyc=%0d: got rden/valid/done/busy=%b, expected %b", name, cyc,
                             {custom_rden_b, rd_valid, rd_done, rd_busy},
                             {cyc <= len, cyc >= 4 && cyc <= len + 3, cyc == len + 4, cyc <= len + 4});
                end
            end
            if (prev_stall) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== prev_data) begin
                    errors++;
                    $display("[TB] FAIL %s_stall_hold: got valid=%b data=%h, expected 1/%h", name, rd_valid, rd_data, prev_data);
                end
            end
            if (custom_rden_b) begin
                checks++;
                if (issued - accepted >= FIFO_DEPTH) begin
                    errors++;
                    $display("[TB] FAIL %s_credit: rden with outstanding=%0d, required < %0d", name, issued - accepted, FIFO_DEPTH);
                end
                checks++;
                if (exp_addr.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL %s_extra_rden: got rden at addr %h, expected none", name, custom_rd_addr);
                end else begin
                    a = exp_addr.pop_front();
                    if (custom_rd_addr !== a) begin
                        errors++;
                        $display("[TB] FAIL %s_addr: got %h, expected %h", name, custom_rd_addr, a);
                    end
                end
                issued++;
            end
            if (toggle) rd_ready = cyc[0];
            if (rd_valid && rd_ready) begin
                checks++;
                if (exp_data.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL %s_extra_word: got %h, expected none", name, rd_data);
                end else begin
                    d = exp_data.pop_front();
                    if (rd_data !== d) begin
                        errors++;
                        $display("[TB] FAIL %s_data: got %h, expected %h", name, rd_data, d);
                    end
                end
                accepted++;
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
            if (rd_done) done = 1;
            @(negedge clk);
        end
        checks++;
        if (!done || exp_data.size() != 0 || exp_addr.size() != 0 || accepted != len) begin
            errors++;
            $display("[TB] FAIL %s_complete: got done=%0d accepted=%0d left=%0d/%0d, expected 1/%0d/0/0",
                     name, done, accepted, exp_data.size(), exp_addr.size(), len);
        end
        rd_ready = 1'b1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 8; i++) ram[i] = W_DATA'(i);
        test_stream("basic", 12'd0, 8, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        test_stream("backpressure", 12'd0, 8, 1'b1, 1'b0);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) ram[(4094 + i) % 4096] = {$urandom, $urandom, $urandom, $urandom};
        test_stream("wrap", 12'd4094, 4, 1'b0, 1'b1);
    endtask

    task automatic test_zero_and_busy();
        logic [W_DATA-1:0] d;
        logic [W_ADDR-1:0] a;
        int dones = 0;
        start_block(12'd100, '0);
        checks++;
        if ({rd_done, custom_rden_b} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL zero_len_done: got done/rden=%b, expected 10", {rd_done, custom_rden_b});
        end
        @(negedge clk);
        checks++;
        if ({rd_done, custom_rden_b, rd_busy} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL zero_len_after: got done/rden/busy=%b, expected 000", {rd_done, custom_rden_b, rd_busy});
        end
        exp_data.delete();
        exp_addr.delete();
        for (int i = 0; i < 6; i++) begin
            ram[200 + i] = {$urandom, $urandom, $urandom, $urandom};
            exp_addr.push_back(W_ADDR'(200 + i));
            exp_data.push_back(ram[200 + i]);
        end
        start_block(12'd200, 13'd6);
        for (int cyc = 1; cyc <= 60 && dones == 0; cyc++) begin
            if (cyc == 2) begin
                rd_base_addr = 12'd900;
                rd_len       = 13'd3;
                rd_start     = 1'b1;
            end else begin
                rd_start     = 1'b0;
            end
            if (custom_rden_b) begin
                checks++;
                a = (exp_addr.size() != 0) ? exp_addr.pop_front() : 12'hfff;
                if (custom_rd_addr !== a) begin
                    errors++;
                    $display("[TB] FAIL busy_addr: got %h, expected %h", custom_rd_addr, a);
                end
            end
            if (rd_valid && rd_ready) begin
                checks++;
                d = (exp_data.size() != 0) ? exp_data.pop_front() : '1;
                if (rd_data !== d) begin
                    errors++;
                    $display("[TB] FAIL busy_data: got %h, expected %h", rd_data, d);
                end
            end
            if (rd_done) dones++;
            @(negedge clk);
        end
        rd_start = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            checks++;
            if ({custom_rden_b, rd_valid, rd_done} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL busy_ignored: got rden/valid/done=%b, expected 000", {custom_rden_b, rd_valid, rd_done});
            end
            @(negedge clk);
        end
        checks++;
        if (dones != 1 || exp_data.size() != 0 || exp_addr.size() != 0) begin
            errors++;
            $display("[TB] FAIL busy_complete: got dones=%0d left=%0d, expected 1/0", dones, exp_data.size());
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) ram[32 + i] = {$urandom, $urandom, $urandom, $urandom};
        rd_ready = 1'b1;
        start_block(12'd32, 13'd8);
        repeat (3) @(negedge clk);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== ram[32]) begin
            errors++;
            $display("[TB] FAIL mid_first_word: got valid=%b data=%h, expected 1/%h", rd_valid, rd_data, ram[32]);
        end
        @(negedge clk);
        rd_ready   = 1'b0;
        custom_rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({custom_rden_b, rd_valid, rd_busy, rd_done} !== 4'b0000 || rd_data !== '0 || custom_rd_addr !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: got rden/valid/busy/done=%b data=%h addr=%h, expected 0000/0/0",
                     {custom_rden_b, rd_valid, rd_busy, rd_done}, rd_data, custom_rd_addr);
        end
        custom_rst = 1'b0;
        rd_ready   = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            checks++;
            if ({custom_rden_b, rd_valid, rd_done} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL mid_no_late_data: got rden/valid/done=%b, expected 000", {custom_rden_b, rd_valid, rd_done});
            end
        end
        for (int i = 0; i < 5; i++) ram[48 + i] = {$urandom, $urandom, $urandom, $urandom};
        test_stream("after_reset", 12'd48, 5, 1'b0, 1'b1);
    endtask

    task automatic test_check();
        logic [1:0] want;
        custom_rst = 1'b1;
        repeat (2) @(negedge clk);
        custom_rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) ram[i] = {$urandom, $urandom, $urandom, $urandom};
        ram[5] = 128'hffffffff50;
        test_stream("check_good", 12'd0, 8, 1'b0, 1'b0);
`ifdef CUSTOM_READ_CHECK_EN
        want = 2'b10;
`else
        want = 2'b00;
`endif
        checks++;
        if ({check_seen, check_fail} !== want) begin
            errors++;
            $display("[TB] FAIL check_good_flags: got seen/fail=%b, expected %b", {check_seen, check_fail}, want);
        end
        ram[5] = '0;
        test_stream("check_bad", 12'd0, 8, 1'b0, 1'b0);
`ifdef CUSTOM_READ_CHECK_EN
        want = 2'b11;
`else
        want = 2'b00;
`endif
        checks++;
        if ({check_seen, check_fail} !== want) begin
            errors++;
            $display("[TB] FAIL check_bad_flags: got seen/fail=%b, expected %b", {check_seen, check_fail}, want);
        end
    endtask

    task automatic test_no_overflow();
        checks++;
        if (overflow_cnt != 0) begin
            errors++;
            $display("[TB] FAIL no_overflow: got %0d overflow pushes, expected 0", overflow_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = '0;
        for (int k = 0; k < RD_LAT; k++) pipe[k] = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_and_busy();
        test_reset_mid();
        test_check();
        test_no_overflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
